// File: rtl/rle_sched_if.sv
// rle_sched_if: requester, stream and RLE-core signals of the job scheduler
interface rle_sched_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
);
    logic req0, req1, gnt0, gnt1;
    logic [LEN_W-1:0] len0, len1;
    logic s_valid, s_ready;
    logic [WIDTH-1:0] s_data;
    logic core_res, core_dir, core_en;
    logic [WIDTH-1:0] core_datain, core_outdata;
    logic m_valid;
    logic [WIDTH-1:0] m_data;
    logic busy, done;
    modport master (
        input  req0, len0, req1, len1, s_valid, s_data, core_outdata,
        output gnt0, gnt1, s_ready, core_res, core_dir, core_datain, core_en,
               m_valid, m_data, busy, done
    );
    modport slave (
        output req0, len0, req1, len1, s_valid, s_data, core_outdata,
        input  gnt0, gnt1, s_ready, core_res, core_dir, core_datain, core_en,
               m_valid, m_data, busy, done
    );
endinterface

// File: rtl/rle_sched.sv
// rle_sched: round-robin job scheduler feeding a shared RLE core (encode for
// requester 0, decode for requester 1), with core flush and result drain.
module rle_sched #(
    parameter int WIDTH     = 32,
    parameter int LEN_W     = 8,
    parameter int FLUSH_CYC = 2,
    parameter int CORE_LAT  = 1
) (
    input logic clock,
    input logic sysres,
    rle_sched_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, RUN = 3'd2, DRAIN = 3'd3, DONE = 3'd4;

    logic [2:0] state;
    logic [LEN_W-1:0] cnt;
    logic [3:0] tick;
    logic owner, ptr, dir, en;
    logic [WIDTH-1:0] din;
    logic [CORE_LAT-1:0] dly;
    logic win, ready, acc;

    assign win = (bus.req0 && bus.req1) ? ptr : bus.req1;
    assign ready = (state == RUN) && (cnt != '0);
    assign acc = ready && bus.s_valid;

    always_ff @(posedge clock or posedge sysres) begin
        if (sysres) begin
            state <= IDLE;
            cnt <= '0;
            tick <= '0;
            owner <= 1'b0;
            ptr <= 1'b0;
            dir <= 1'b0;
            en <= 1'b0;
            din <= '0;
            dly <= '0;
        end else begin
            en <= acc;
            dly <= CORE_LAT'({dly, en});
            if (acc) begin
                din <= bus.s_data;
                cnt <= cnt - LEN_W'(1);
            end
            case (state)
                IDLE: if (bus.req0 || bus.req1) begin
                    state <= CLEAR;
                    owner <= win;
                    dir <= !win;
                    cnt <= win ? bus.len1 : bus.len0;
                    tick <= '0;
                end
                CLEAR: if (tick == 4'(FLUSH_CYC - 1)) begin
                    tick <= '0;
                    state <= (cnt == '0) ? DRAIN : RUN;
                end else tick <= tick + 4'd1;
                // one extra RUN cycle after the last accept lets s_ready fall before draining
                RUN: if (cnt == '0) state <= DRAIN;
                DRAIN: if (tick == 4'(CORE_LAT - 1)) begin
                    tick <= '0;
                    state <= DONE;
                end else tick <= tick + 4'd1;
                default: begin
                    ptr <= !owner;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0 = (state != IDLE) && !owner;
    assign bus.gnt1 = (state != IDLE) && owner;
    assign bus.s_ready = ready;
    assign bus.core_res = sysres || (state == CLEAR);
    assign bus.core_dir = dir;
    assign bus.core_datain = din;
    assign bus.core_en = en;
    assign bus.m_valid = dly[CORE_LAT-1];
    assign bus.m_data = bus.core_outdata;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
endmodule

// File: tb/tb_rle_sched.sv
// tb_rle_sched: directed and random jobs checked cycle by cycle against a
// timeline computed from the job length, valid pattern and round-robin pointer.
module tb_rle_sched;
    localparam int FLUSH = 2;
    localparam int LAT = 1;
    localparam logic [31:0] KEY = 32'h5A5A_1234;

    logic clock, sysres;
    int vectors = 0, errs = 0;
    bit ptr_m = 0, dir_m = 0;
    logic [31:0] last_in = '0;
    bit pat[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] fixed[5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF};

    rle_sched_if #(.WIDTH(32), .LEN_W(8)) bus ();
    rle_sched #(.WIDTH(32), .LEN_W(8), .FLUSH_CYC(FLUSH), .CORE_LAT(LAT)) dut (
        .clock(clock), .sysres(sysres), .bus(bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // stand-in core: one-cycle latency, recognisable transform of the input word
    always_ff @(posedge clock) bus.core_outdata <= bus.core_datain ^ KEY;

    function automatic logic [8:0] ctrl();
        return {bus.gnt0, bus.gnt1, bus.core_res, bus.s_ready, bus.core_en,
                bus.m_valid, bus.busy, bus.done, bus.core_dir};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        sysres = 1'b1;
        #1;
        chk("rst_ctrl", 64'(ctrl()), 64'h040);
        chk("rst_datain", 64'(bus.core_datain), 64'h0);
        repeat (cycles) begin
            @(negedge clock);
            chk("rst_hold", 64'(ctrl()), 64'h040);
        end
        sysres = 1'b0;
        {bus.req1, bus.req0} = 2'b00;
        bus.s_valid = 1'b0;
        last_in = '0;
        dir_m = 1'b0;
        ptr_m = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] mask, input int len, input int mode,
                           input bit hold, input bit use_fixed, input int abort_k);
        bit vp[1024];
        bit acc[1024];
        logic [31:0] wd[1024];
        int r, a, n, dk;
        bit win, bsy;
        logic [8:0] ev;
        win = (mask == 2'b11) ? ptr_m : (mask == 2'b10);
        r = 1 + FLUSH;
        a = -1;
        n = 0;
        for (int i = 0; i < 1024; i++) begin
            vp[i] = (mode == 0) ? 1'b1 : (mode == 2) ? (i < 8 ? pat[i] : 1'b1) : 1'($urandom_range(0, 1));
            acc[i] = 1'b0;
            wd[i] = $urandom;
        end
        for (int k = r; n < len && k < 1024; k++)
            if (vp[k-r]) begin
                acc[k] = 1'b1;
                if (use_fixed) wd[k] = fixed[n];
                n++;
                a = k;
            end
        dk = (len == 0) ? r + LAT : a + 2 + LAT;
        for (int k = 0; k <= dk; k++) begin
            @(negedge clock);
            if (k == abort_k) begin
                do_reset(5);
                return;
            end
            bsy = k >= 1;
            if (k == 1) dir_m = !win;
            ev = {bsy && !win, bsy && win, k >= 1 && k <= FLUSH, len > 0 && k >= r && k <= a,
                  k >= 1 && acc[k-1], k >= 1 + LAT && acc[k-1-LAT], bsy, k == dk, dir_m};
            chk("ctrl", 64'(ctrl()), 64'(ev));
            chk("datain", 64'(bus.core_datain), 64'(last_in));
            if (k >= 1 + LAT && acc[k-1-LAT])
                chk("mdata", 64'(bus.m_data), 64'(wd[k-1-LAT] ^ KEY));
            if (acc[k]) last_in = wd[k];
            if (k == 0 || hold) begin
                {bus.req1, bus.req0} = mask;
                bus.len0 = 8'(len);
                bus.len1 = 8'(len);
            end else begin
                {bus.req1, bus.req0} = (k == dk) ? 2'b00 : 2'($urandom_range(0, 3));
                bus.len0 = 8'($urandom);
                bus.len1 = 8'($urandom);
            end
            bus.s_valid = (k >= r && k <= a) ? vp[k-r] : 1'($urandom_range(0, 1));
            bus.s_data = wd[k];
        end
        ptr_m = !win;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        {bus.req1, bus.req0} = 2'b00;
        bus.len0 = '0;
        bus.len1 = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        @(negedge clock);
        do_reset(3);
        // contention from a fresh pointer: 0,1,0,1 with requests held throughout
        for (int j = 0; j < 4; j++) run_job(2'b11, 1 + j, 0, 1'b1, 1'b0, -1);
        run_job(2'b01, 5, 0, 1'b0, 1'b1, -1);
        run_job(2'b10, 3, 2, 1'b0, 1'b0, -1);
        run_job(2'b10, 0, 0, 1'b0, 1'b0, -1);
        run_job(2'b01, 2, 1, 1'b0, 1'b0, -1);
        // pointer now favours requester 1; reset must return it to 0
        run_job(2'b01, 5, 0, 1'b0, 1'b0, 1 + FLUSH + 2);
        run_job(2'b11, 4, 1, 1'b0, 1'b0, -1);
        run_job(2'b01, 255, 0, 1'b0, 1'b0, -1);
        for (int j = 0; j < 20; j++)
            run_job(2'($urandom_range(1, 3)), $urandom_range(0, 20), 1,
                    (j < 19) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/rle_sched.md
RLE_SCHED -- requirements
Module: rle_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width, matching the RLE core datain/outdata.
REQ-002 SHALL have parameter LEN_W, default 8: job length counter width.
REQ-003 SHALL have parameter FLUSH_CYC, default 2: cycles core_res is held between jobs, 1..15.
REQ-004 SHALL have parameter CORE_LAT, default 1: RLE core datain-to-outdata latency in cycles, 1..7.
REQ-005 SHALL have ports:
  clock  in  1  single clock, all state on rising edge
  sysres  in  1  reset, asynchronous, active-high
  req0  in  1  requester 0 job request, encode (dir=1)
  len0  in  LEN_W  requester 0 job length in words
  req1  in  1  requester 1 job request, decode (dir=0)
  len1  in  LEN_W  requester 1 job length in words
  gnt0 / gnt1  out  1  grant to requester 0 / 1
  s_valid  in  1  word offered by the granted requester
  s_data  in  WIDTH  offered word
  s_ready  out  1  controller accepts s_data this cycle
  core_res  out  1  RLE core reset
  core_dir  out  1  RLE core direction
  core_datain  out  WIDTH  RLE core input word
  core_en  out  1  core_datain is a new word this cycle
  core_outdata  in  WIDTH  RLE core output word
  m_valid / m_data  out  1 / WIDTH  result stream, no backpressure
  busy  out  1  high in any state but IDLE
  done  out  1  one-cycle job-complete pulse

Function
REQ-006 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-007 IDLE: SHALL sample req0/req1 each cycle; if any is high, go to CLEAR next cycle, latching the winner, its len, and core_dir (1 for req0, 0 for req1).
REQ-008 Arbitration SHALL be round-robin: a lone requester wins; if both are high, the side selected by the priority pointer wins; the pointer resets to 0 and moves to the loser on each DONE.
REQ-009 Grant for the winner SHALL be asserted from CLEAR through DONE inclusive; at most one grant is high at any time.
REQ-010 CLEAR: core_res SHALL be 1 for exactly FLUSH_CYC cycles, then the FSM goes to RUN; if the latched len is 0, it goes to DRAIN instead.
REQ-011 RUN: s_ready SHALL be 1; on s_valid and s_ready, core_datain takes s_data, core_en is 1 the next cycle, and the remaining count decrements.
REQ-012 RUN gap (s_valid=0): core_en SHALL be 0 and core_datain holds its last value.
REQ-013 After the word that brings the count to 0 is accepted, s_ready SHALL drop the next cycle and the FSM goes to DRAIN.
REQ-014 m_valid SHALL equal core_en delayed by CORE_LAT cycles; m_data SHALL equal core_outdata whenever m_valid is 1.
REQ-015 DRAIN SHALL last CORE_LAT cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle: done=1, pointer updated, grant dropped the next cycle, FSM returns to IDLE.
REQ-017 Request level or len changes after IDLE sampling SHALL be ignored; a job always runs to completion.
REQ-018 The count SHALL be LEN_W bits and SHALL never wrap: accepts stop at 0, and a len of all-ones transfers 2^LEN_W-1 words.
REQ-019 Minimum job-to-job spacing SHALL be one IDLE cycle.

Reset
REQ-020 While sysres is 1, asynchronously and regardless of state: FSM=IDLE, pointer=0, counters=0, delay line cleared.
REQ-021 While sysres is 1: outputs gnt0, gnt1, s_ready, core_en, m_valid, busy, done, core_dir SHALL be 0; core_datain SHALL be 0; core_res SHALL be 1.
REQ-022 After sysres deasserts, the first arbitration SHALL occur in the first IDLE cycle; a job in progress SHALL be abandoned with no done pulse.

Verification
REQ-023 Single job: req0=1, len0=5 at cycle 0, defaults, s_valid always 1, data DEADBEEF x3 then FFFFFFFF x2 -> gnt0 high from cycle 1; core_res high in cycles 1-2; s_ready high in cycles 3-7; core_dir=1; 5 m_valid cycles; done in cycle 10.
REQ-024 Contention: req0=req1=1 held continuously -> grant order 0,1,0,1; one IDLE cycle between each job; never two grants at once.
REQ-025 Gaps: len1=3, s_valid pattern 1,0,0,1,1 -> exactly 3 core_en pulses; core_datain held during the gaps; core_dir=0; done one cycle after DRAIN.
REQ-026 Zero length: req1=1, len1=0 -> CLEAR for 2 cycles; s_ready never 1; m_valid never 1; done pulse; back to IDLE.
REQ-027 Reset mid-RUN: sysres=1 for 5 cycles after the 2nd accept of a len=5 job -> all outputs reach reset values immediately; no done pulse; a new req0 after release is granted with pointer=0.
